// File: rtl/pll_clken_mgr.sv
// pll_clken_mgr: qualifies the PLL lock and generates NCH
// run-time programmable, phase-aligned clock-enable streams.
module pll_clken_mgr #(
    parameter int NCH           = 4,
    parameter int DIV_W         = 6,
    parameter int STABLE_CYCLES = 16,
    parameter int DEFAULT_DIV   = 30,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic [NCH-1:0]   ch_en,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   clkout,
    output logic             ready,
    output logic             lock_lost
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RUN,
        LOST
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] stab_cnt;
    logic [SW-1:0] stab_nx;
    logic [1:0]    sync;
    logic          lk;
    logic          run_ok;
    logic          run_entry;

    assign lk        = sync[1];
    assign ready     = (state == RUN);
    assign run_ok    = (state == RUN) && lk;
    assign run_entry = (state_nx == RUN) && (state != RUN);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            stab_cnt  <= '0;
            sync      <= '0;
            lock_lost <= 1'b0;
        end else begin
            state    <= state_nx;
            stab_cnt <= stab_nx;
            sync     <= {sync[0], pll_lock};
            if (state == RUN && !lk)
                lock_lost <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        stab_nx  = stab_cnt;
        unique case (state)
            WAIT_LOCK: begin
                if (lk) begin
                    state_nx = STABLE;
                    stab_nx  = '0;
                end
            end
            STABLE: begin
                if (!lk)
                    state_nx = WAIT_LOCK;
                else if (stab_cnt == STAB_LAST)
                    state_nx = RUN;
                else
                    stab_nx = stab_cnt + 1'b1;
            end
            RUN: begin
                if (!lk)
                    state_nx = LOST;
            end
            LOST: begin
                state_nx = WAIT_LOCK;
            end
            default: begin
                state_nx = WAIT_LOCK;
            end
        endcase
    end

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] div_sh;
        logic [DIV_W-1:0] ph_sh;
        logic [DIV_W-1:0] div_ac;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] de;
        logic [DIV_W-1:0] de_sh;
        logic [DIV_W-1:0] ld_val;
        logic             en_q;
        logic             t_q;
        logic             c_q;
        logic             ld;
        logic             wr;
        logic             wrap;

        assign de     = eff_div(div_ac);
        assign de_sh  = eff_div(div_sh);
        // the shadow becomes active on load, so it sets the load value
        assign ld_val = (ph_sh >= de_sh) ? '0 : ph_sh;
        assign ld     = run_entry ||
                        (state == RUN && ch_en[i] && !en_q);
        assign wr     = cfg_wr && (cfg_ch == CH_W'(i));
        assign wrap   = (cnt == de - DIV_W'(1));

        assign tick[i]   = t_q;
        assign clkout[i] = c_q;

        always_ff @(posedge clkin) begin
            if (reset) begin
                div_sh <= DIV_RST;
                ph_sh  <= '0;
                div_ac <= DIV_RST;
                cnt    <= '0;
                en_q   <= 1'b0;
                t_q    <= 1'b0;
                c_q    <= 1'b0;
            end else begin
                en_q <= ch_en[i];
                t_q  <= 1'b0;
                c_q  <= 1'b0;
                if (wr) begin
                    div_sh <= cfg_div;
                    ph_sh  <= cfg_phase;
                end
                if (ld) begin
                    cnt    <= ld_val;
                    div_ac <= div_sh;
                end else if (run_ok && ch_en[i]) begin
                    t_q <= wrap;
                    c_q <= (cnt < (de >> 1));
                    if (wrap) begin
                        cnt    <= '0;
                        div_ac <= div_sh;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
            end
        end
    end

endmodule
